// File: rtl/sr_chain_ctrl.sv
// Serial driver for a daisy-chain of 595-style 8-bit shift/latch registers.
// Optional LED-reset frame (zeros + hold) is enabled by defining SR_CHAIN_LED_RESET_EN.
module sr_chain_ctrl #(
  parameter int CHAIN_LEN    = 4,
  parameter int CLK_DIV      = 5,
  parameter bit MSB_FIRST    = 1'b1
`ifdef SR_CHAIN_LED_RESET_EN
  , parameter int RESET_CYCLES = 10000
`endif
) (
  input  logic                   clk_200,
  input  logic                   ar,
  input  logic [8*CHAIN_LEN-1:0] data_in,
  input  logic                   data_valid,
`ifdef SR_CHAIN_LED_RESET_EN
  input  logic                   led_reset,
`endif
  output logic                   data_ready,
  output logic                   sr_clk,
  output logic                   r_clk,
  output logic                   ser_out,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int NB      = 8 * CHAIN_LEN;
  localparam int BIT_W   = $clog2(NB);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DIV_PRE = (CLK_DIV >= 2) ? CLK_DIV - 2 : 0;

  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(NB - 1);
  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_BEFORE   = DIV_W'(DIV_PRE);

`ifdef SR_CHAIN_LED_RESET_EN
  localparam int HOLD_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int HOLD_PRE = (RESET_CYCLES >= 2) ? RESET_CYCLES - 2 : 0;
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_BEFORE = HOLD_W'(HOLD_PRE);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH,
    S_GAP
`ifdef SR_CHAIN_LED_RESET_EN
    , S_HOLD
`endif
  } state_t;

  state_t            state;
  logic [NB-1:0]     shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DIV_W-1:0]  div_cnt;
`ifdef SR_CHAIN_LED_RESET_EN
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_req;
`endif

  logic              accept;
  logic [NB-1:0]     load_word;

  // Bit that goes on the wire first from a given shift-register value.
  function automatic logic head(input logic [NB-1:0] v);
    return MSB_FIRST ? v[NB-1] : v[0];
  endfunction

  function automatic logic [NB-1:0] advance(input logic [NB-1:0] v);
    return MSB_FIRST ? {v[NB-2:0], 1'b0} : {1'b0, v[NB-1:1]};
  endfunction

  // data_ready is only ever high in IDLE, so accept implies IDLE.
  always_comb begin
    accept    = data_ready && data_valid;
    load_word = data_in;
`ifdef SR_CHAIN_LED_RESET_EN
    if (data_ready && led_reset) begin
      accept    = 1'b1;
      load_word = '0;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clk_200 or negedge ar) begin
    if (!ar) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      data_ready <= 1'b0;
      sr_clk     <= 1'b0;
      r_clk      <= 1'b0;
      ser_out    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SR_CHAIN_LED_RESET_EN
      hold_cnt   <= '0;
      hold_req   <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          sr_clk <= 1'b0;
          r_clk  <= 1'b0;
          if (accept) begin
            state      <= S_SHIFT;
            shreg      <= load_word;
            ser_out    <= head(load_word);
            bit_cnt    <= '0;
            div_cnt    <= '0;
            data_ready <= 1'b0;
            busy       <= 1'b1;
`ifdef SR_CHAIN_LED_RESET_EN
            hold_req   <= led_reset;
`endif
          end else begin
            data_ready <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!sr_clk) begin
              sr_clk <= 1'b1;
            end else begin
              sr_clk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= S_LATCH;
                r_clk <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= advance(shreg);
                ser_out <= head(advance(shreg));
              end
            end
          end
        end

        S_LATCH: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt    <= '0;
            r_clk      <= 1'b0;
            ser_out    <= 1'b0;
            state      <= S_GAP;
`ifdef SR_CHAIN_LED_RESET_EN
            frame_done <= (CLK_DIV == 1) && !hold_req;
`else
            frame_done <= (CLK_DIV == 1);
`endif
          end
        end

        S_GAP: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt    <= div_cnt + 1'b1;
`ifdef SR_CHAIN_LED_RESET_EN
            frame_done <= (div_cnt == DIV_BEFORE) && !hold_req;
`else
            frame_done <= (div_cnt == DIV_BEFORE);
`endif
          end else begin
            div_cnt <= '0;
`ifdef SR_CHAIN_LED_RESET_EN
            if (hold_req) begin
              state      <= S_HOLD;
              hold_cnt   <= '0;
              frame_done <= (RESET_CYCLES == 1);
            end else begin
              state      <= S_IDLE;
              data_ready <= 1'b1;
              busy       <= 1'b0;
            end
`else
            state      <= S_IDLE;
            data_ready <= 1'b1;
            busy       <= 1'b0;
`endif
          end
        end

`ifdef SR_CHAIN_LED_RESET_EN
        S_HOLD: begin
          if (hold_cnt != HOLD_LAST) begin
            hold_cnt   <= hold_cnt + 1'b1;
            frame_done <= (hold_cnt == HOLD_BEFORE);
          end else begin
            hold_cnt   <= '0;
            hold_req   <= 1'b0;
            state      <= S_IDLE;
            data_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
`endif

        default: begin
          state      <= S_IDLE;
          sr_clk     <= 1'b0;
          r_clk      <= 1'b0;
          ser_out    <= 1'b0;
          busy       <= 1'b0;
          data_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_chain_ctrl.sv
// Directed bench for sr_chain_ctrl: 8-bit chains (MSB/LSB first), a 32-bit chain
// (back-to-back, abort, busy poke) and, when SR_CHAIN_LED_RESET_EN is defined, the LED-reset frame.
module tb_sr_chain_ctrl;

  logic clk_200 = 1'b0;
  always #5 clk_200 = ~clk_200;

  logic ar;

  logic [7:0]  a_data, b_data;
  logic [31:0] c_data;
  logic        a_valid, b_valid, c_valid;
  logic        a_ready, a_sr, a_r, a_ser, a_busy, a_done;
  logic        b_ready, b_sr, b_r, b_ser, b_busy, b_done;
  logic        c_ready, c_sr, c_r, c_ser, c_busy, c_done;

  sr_chain_ctrl #(.CHAIN_LEN(1), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_a (
    .clk_200(clk_200), .ar(ar), .data_in(a_data), .data_valid(a_valid),
`ifdef SR_CHAIN_LED_RESET_EN
    .led_reset(1'b0),
`endif
    .data_ready(a_ready), .sr_clk(a_sr), .r_clk(a_r), .ser_out(a_ser),
    .busy(a_busy), .frame_done(a_done)
  );

  sr_chain_ctrl #(.CHAIN_LEN(1), .CLK_DIV(2), .MSB_FIRST(1'b0)) u_b (
    .clk_200(clk_200), .ar(ar), .data_in(b_data), .data_valid(b_valid),
`ifdef SR_CHAIN_LED_RESET_EN
    .led_reset(1'b0),
`endif
    .data_ready(b_ready), .sr_clk(b_sr), .r_clk(b_r), .ser_out(b_ser),
    .busy(b_busy), .frame_done(b_done)
  );

  sr_chain_ctrl #(.CHAIN_LEN(4), .CLK_DIV(5), .MSB_FIRST(1'b1)) u_c (
    .clk_200(clk_200), .ar(ar), .data_in(c_data), .data_valid(c_valid),
`ifdef SR_CHAIN_LED_RESET_EN
    .led_reset(1'b0),
`endif
    .data_ready(c_ready), .sr_clk(c_sr), .r_clk(c_r), .ser_out(c_ser),
    .busy(c_busy), .frame_done(c_done)
  );

`ifdef SR_CHAIN_LED_RESET_EN
  logic [7:0] d_data;
  logic       d_valid, d_led;
  logic       d_ready, d_sr, d_r, d_ser, d_busy, d_done;

  sr_chain_ctrl #(.CHAIN_LEN(1), .CLK_DIV(2), .MSB_FIRST(1'b1), .RESET_CYCLES(20)) u_d (
    .clk_200(clk_200), .ar(ar), .data_in(d_data), .data_valid(d_valid),
    .led_reset(d_led),
    .data_ready(d_ready), .sr_clk(d_sr), .r_clk(d_r), .ser_out(d_ser),
    .busy(d_busy), .frame_done(d_done)
  );
`endif

  // Small-chain view selected between u_a (sel=0) and u_b (sel=1).
  logic sel;
  logic m_ready, m_sr, m_r, m_ser, m_busy, m_done;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_sr    = sel ? b_sr    : a_sr;
  assign m_r     = sel ? b_r     : a_r;
  assign m_ser   = sel ? b_ser   : a_ser;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;

  typedef struct {
    logic       sel;
    logic [7:0] data;
    logic [7:0] seq;   // expected wire order, first bit in seq[7]
    string      name;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_small(input vec_t v);
    logic [5:0] got, exp;
    logic [7:0] bits;
    logic       prev, ser_exp;
    int         rises;
    sel = v.sel;
    for (int i = 0; i < 100 && !m_ready; i++) @(negedge clk_200);
    check({v.name, "_ready"}, m_ready, 1);
    if (v.sel) begin b_data = v.data; b_valid = 1'b1; end
    else       begin a_data = v.data; a_valid = 1'b1; end
    @(posedge clk_200);
    #1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data  = ~v.data; b_data = ~v.data;
    bits = '0; rises = 0; prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_200);
      if (k < 32)      ser_exp = v.seq[7 - k/4];
      else if (k < 34) ser_exp = v.seq[0];
      else             ser_exp = 1'b0;
      exp = {(k < 32) && (k % 4 >= 2), (k == 32) || (k == 33), ser_exp,
             k < 36, k >= 36, k == 35};
      got = {m_sr, m_r, m_ser, m_busy, m_ready, m_done};
      check($sformatf("%s_k%0d", v.name, k), got, exp);
      if (m_sr && !prev) begin rises++; bits = {bits[6:0], m_ser}; end
      prev = m_sr;
    end
    check({v.name, "_rises"}, rises, 8);
    check({v.name, "_bits"}, bits, v.seq);
  endtask

  // Called on the first negedge of a u_c frame (busy just risen).
  task automatic track_c(input string name, input logic [31:0] exp_word, input bit poke);
    int          len, rises, rp, overlap, ready_bad, done_at;
    logic [31:0] bits;
    logic        psr, pr;
    len = 0; rises = 0; rp = 0; overlap = 0; ready_bad = 0; done_at = -1;
    bits = '0; psr = 1'b0; pr = 1'b0;
    while (c_busy && len < 400) begin
      if (c_sr && !psr) begin rises++; bits = {bits[30:0], c_ser}; end
      if (c_r && !pr) rp++;
      if (c_sr && c_r) overlap++;
      if (c_ready) ready_bad++;
      if (c_done) done_at = len;
      if (poke && len == 50) begin c_valid = 1'b1; c_data = ~exp_word; end
      if (poke && len == 51) c_valid = 1'b0;
      psr = c_sr; pr = c_r; len++;
      @(negedge clk_200);
    end
    check({name, "_len"}, len, 330);
    check({name, "_rises"}, rises, 32);
    check({name, "_bits"}, bits, exp_word);
    check({name, "_rpulse"}, rp, 1);
    check({name, "_overlap"}, overlap, 0);
    check({name, "_ready_busy"}, ready_bad, 0);
    check({name, "_done_at"}, done_at, 329);
    check({name, "_ready_end"}, c_ready, 1);
  endtask

  initial begin
    int   rises, rp;
    logic psr;

    vecs[0] = '{sel: 1'b0, data: 8'hA5, seq: 8'b1010_0101, name: "msb_a5"};
    vecs[1] = '{sel: 1'b0, data: 8'h3C, seq: 8'b0011_1100, name: "msb_3c"};
    vecs[2] = '{sel: 1'b0, data: 8'hFF, seq: 8'b1111_1111, name: "msb_ff"};
    vecs[3] = '{sel: 1'b1, data: 8'h01, seq: 8'b1000_0000, name: "lsb_01"};
    vecs[4] = '{sel: 1'b1, data: 8'h0F, seq: 8'b1111_0000, name: "lsb_0f"};
    vecs[5] = '{sel: 1'b1, data: 8'h80, seq: 8'b0000_0001, name: "lsb_80"};

    ar = 1'b0; sel = 1'b0;
    a_data = '0; b_data = '0; c_data = '0;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
`ifdef SR_CHAIN_LED_RESET_EN
    d_data = '0; d_valid = 1'b0; d_led = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk_200);
    check("rst_a", {a_ready, a_sr, a_r, a_ser, a_busy, a_done}, 0);
    check("rst_b", {b_ready, b_sr, b_r, b_ser, b_busy, b_done}, 0);
    check("rst_c", {c_ready, c_sr, c_r, c_ser, c_busy, c_done}, 0);
    ar = 1'b1;
    @(negedge clk_200);
    check("rel_ready_a", a_ready, 1);
    check("rel_ready_c", c_ready, 1);

    for (int i = 0; i < 6; i++) run_small(vecs[i]);

    // Back-to-back frames with data_valid held high
    for (int i = 0; i < 100 && !c_ready; i++) @(negedge clk_200);
    c_data = 32'hDEADBEEF; c_valid = 1'b1;
    @(posedge clk_200);
    @(negedge clk_200);
    c_data = 32'h0000_0000;
    track_c("b2b0", 32'hDEADBEEF, 1'b0);
    @(negedge clk_200);
    check("b2b_one_idle", c_busy, 1);
    c_valid = 1'b0;
    track_c("b2b1", 32'h0000_0000, 1'b0);

    // Abort during bit 12
    for (int i = 0; i < 100 && !c_ready; i++) @(negedge clk_200);
    c_data = 32'h1234_5678; c_valid = 1'b1;
    @(posedge clk_200);
    #1 c_valid = 1'b0;
    rises = 0; psr = 1'b0;
    for (int i = 0; i < 400 && rises < 13; i++) begin
      @(negedge clk_200);
      if (c_sr && !psr) rises++;
      psr = c_sr;
    end
    check("abort_reached_bit12", rises, 13);
    ar = 1'b0;
    #1;
    check("abort_outs", {c_ready, c_sr, c_r, c_ser, c_busy, c_done}, 0);
    rp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_200);
      if (c_r) rp++;
    end
    check("abort_no_latch", rp, 0);
    ar = 1'b1;
    @(negedge clk_200);
    check("abort_ready_after", c_ready, 1);

    // New frame after abort, with a valid pulse while busy
    c_data = 32'hCAFE_0001; c_valid = 1'b1;
    @(posedge clk_200);
    #1 c_valid = 1'b0;
    @(negedge clk_200);
    track_c("post_abort", 32'hCAFE_0001, 1'b1);
    repeat (3) @(negedge clk_200);
    check("poke_no_extra", c_busy, 0);

`ifdef SR_CHAIN_LED_RESET_EN
    begin
      int         len, done_at;
      logic [7:0] bits;
      for (int i = 0; i < 100 && !d_ready; i++) @(negedge clk_200);
      d_data = 8'hFF; d_valid = 1'b1; d_led = 1'b1;
      @(posedge clk_200);
      @(negedge clk_200);
      d_led = 1'b0;
      len = 0; rises = 0; rp = 0; done_at = -1; bits = 8'hAA; psr = 1'b0;
      while (d_busy && len < 200) begin
        if (d_sr && !psr) begin rises++; bits = {bits[6:0], d_ser}; end
        if (d_r && len > 0 && !d_sr) rp += (len == 32) ? 1 : 0;
        if (d_done) done_at = len;
        psr = d_sr; len++;
        @(negedge clk_200);
      end
      check("ledrst_len", len, 56);
      check("ledrst_rises", rises, 8);
      check("ledrst_bits", bits, 8'h00);
      check("ledrst_latch", rp, 1);
      check("ledrst_done_at", done_at, 55);
      check("ledrst_ready", d_ready, 1);
      @(negedge clk_200);
      check("ledrst_data_accept", d_busy, 1);
      d_valid = 1'b0;
      len = 0; bits = '0; psr = 1'b0;
      while (d_busy && len < 200) begin
        if (d_sr && !psr) bits = {bits[6:0], d_ser};
        psr = d_sr; len++;
        @(negedge clk_200);
      end
      check("ledrst_data_len", len, 36);
      check("ledrst_data_bits", bits, 8'hFF);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_chain_ctrl.md
Name: sr_chain_ctrl

Overview:
Parametrised serial driver for a daisy-chain of 8-bit shift/latch registers (595-style) feeding the LED wall.
- Accepts one frame word of CHAIN_LEN×8 bits over a valid/ready handshake.
- Shifts the word out on ser_out with a generated sr_clk, then pulses r_clk to latch all registers at once.
- Sits between the frame/pattern logic and the board-level shift-register chain, and replaces the fixed 8-bit free-running controller.

Parameters:
CHAIN_LEN, 4, number of 8-bit registers in the chain; frame width NB = 8*CHAIN_LEN; legal range ≥1
CLK_DIV, 5, clk_200 cycles per sr_clk half-period (5 → 20 MHz at 200 MHz); legal range ≥1
MSB_FIRST, 1, 1: data_in[NB-1] shifted first; 0: data_in[0] shifted first

Ports:
clk_200  input  1  200 MHz logic clock; all logic on its rising edge
ar  input  1  asynchronous active-low reset
data_in  input  NB  frame data; bit k drives LED k of the chain
data_valid  input  1  frame offered
data_ready  output  1  block can accept a frame
sr_clk  output  1  shift clock to the chain
r_clk  output  1  latch (storage) clock to the chain
ser_out  output  1  serial data to the chain
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse when the latch sequence completes

Behaviour:
- All outputs are registered.
- While ar=0: state IDLE; sr_clk=0, r_clk=0, ser_out=0, busy=0, frame_done=0, data_ready=0; all counters cleared.
- data_ready rises on the first clk_200 edge after ar deasserts.
- Reset asserted mid-frame aborts immediately. No latch pulse is issued and the chain keeps its previously latched contents.
- States: IDLE → SHIFT → LATCH → GAP → IDLE.
- IDLE:
  - data_ready=1, busy=0.
  - Accept when data_valid && data_ready. On that edge: capture data_in into the internal shift register, clear the bit counter, go to SHIFT, data_ready←0, busy←1.
  - data_in is ignored when no transfer occurs.
- SHIFT:
  - Each bit occupies 2*CLK_DIV cycles: sr_clk=0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
  - ser_out is updated on the cycle sr_clk goes low, i.e. the first cycle of each bit. It is stable ≥CLK_DIV cycles before and through the rising edge.
  - The first bit appears on ser_out on the cycle after acceptance, so latency from accept to first ser_out is 1 cycle.
  - Bit counter runs 0..NB-1. After the high phase of bit NB-1: sr_clk←0, go to LATCH.
- LATCH:
  - r_clk=1 for CLK_DIV cycles; sr_clk held 0; ser_out holds the last bit.
  - Then r_clk←0, go to GAP.
- GAP:
  - CLK_DIV cycles with all clocks low and ser_out=0.
  - frame_done=1 on the final GAP cycle; next state IDLE with data_ready=1.
- Frame period from accept edge to data_ready=1 is (2*NB+2)*CLK_DIV cycles.
- Back-to-back frames: data_valid held high gives a new accept on the first IDLE cycle, so there is exactly one IDLE cycle between frames.
- Counter widths: $clog2 of the max count, minimum 1 bit. No wrap occurs inside a frame.
- sr_clk and r_clk are never high simultaneously.

Optional Feature:
Macro SR_CHAIN_LED_RESET_EN.
- Enabled:
  - Adds input port led_reset (1 bit) and parameter RESET_CYCLES (default 10000 = 50 µs).
  - led_reset=1 in IDLE takes priority over data_valid.
  - It shifts NB zeros, latches them (normal SHIFT/LATCH/GAP timing), then enters HOLD for RESET_CYCLES cycles with all outputs low, busy=1 and data_ready=0.
  - frame_done pulses at the end of HOLD, not at the end of GAP.
  - led_reset is ignored outside IDLE.
- Disabled: no port, no HOLD state; behaviour exactly as above.

Test Plan:
- CHAIN_LEN=1, CLK_DIV=2, MSB_FIRST=1, data_in=8'hA5 accepted → ser_out sequence 1,0,1,0,0,1,0,1 sampled at sr_clk rising edges; 8 sr_clk pulses each 2 high/2 low; one r_clk pulse 2 cycles wide; frame_done 36 cycles after accept; data_ready high at cycle 36.
- Same setup with MSB_FIRST=0, data_in=8'h01 → first sampled bit 1, remaining seven 0.
- CHAIN_LEN=4, CLK_DIV=5, data_valid held high with data_in=32'hDEADBEEF then 32'h00000000 → two frames of 330 cycles each, one IDLE cycle between them, exactly 32 sr_clk rising edges per frame, sampled bits match each word in order.
- ar driven low during bit 12 of a frame → all outputs 0 within the same cycle, no r_clk pulse; after release data_ready=1 next edge, and a new frame transmits correctly.
- data_valid pulsed while busy=1 → ignored; no data_ready, no change to the frame in progress.
- SR_CHAIN_LED_RESET_EN defined, RESET_CYCLES=20, led_reset and data_valid both high in IDLE → zeros shifted and latched, then 20 HOLD cycles; frame_done at the end of HOLD; the data frame is accepted afterwards.
